pool_engine: RTL

//  Parametrised 2-D pooling engine, successor to the fixed 2x2 max-pool top.

---
 rtl/pool_engine_pkg.sv | 33 +++
 rtl/pool_engine_if.sv | 27 ++
 rtl/pool_window_acc.sv | 50 +++++
 rtl/pool_engine.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pool_engine_pkg.sv
// Shared types and elaboration-time helpers for the pooling engine.
// Mode and FSM encodings plus the dimension arithmetic used by the top and datapath.
package pool_engine_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } pool_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int out_dim(input int in_dim, input int k, input int stride);
        return (in_dim - k) / stride + 1;
    endfunction

endpackage

// File: rtl/pool_engine_if.sv
// Control and RAM-side bus of the pooling engine.
// The engine is the master; the host/RAM environment is the slave.
interface pool_engine_if #(
    parameter int AW     = 16,
    parameter int DATA_W = 8
);
    logic              start;
    logic              mode;
    logic              busy;
    logic              intr;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  start, mode, rd_data,
        output busy, intr, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, mode, rd_data,
        input  busy, intr, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pool_window_acc.sv
// Per-window accumulator: running max or running sum over one KxK window.
// Tracks the one-cycle read latency itself, so callers only flag each issued read.
module pool_window_acc
    import pool_engine_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              issue_first,
    input  logic              avg,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] result
);
    localparam int SHIFT = 2 * clog2(K);
    localparam int SUM_W = DATA_W + SHIFT;

    logic             valid;
    logic             first;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] din_w;

    assign din_w = SUM_W'(din);

    // NOTE: clocked state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            first <= 1'b0;
            acc   <= '0;
        end else begin
            valid <= issue;
            first <= issue && issue_first;
            if (valid) begin
                if (first)
                    acc <= din_w;
                else if (avg)
                    acc <= acc + din_w;
                else if (din_w > acc)
                    acc <= din_w;
            end
        end
    end

    assign result = avg ? DATA_W'(acc >> SHIFT) : acc[DATA_W-1:0];

endmodule

// File: rtl/pool_engine.sv
// 2-D max/average pooling engine: walks every KxK window of CH planes in a
// data RAM and writes one pooled element per window to an answer RAM.
module pool_engine
    import pool_engine_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int H_IN   = 10,
    parameter int W_IN   = 10,
    parameter int K      = 2,
    parameter int STRIDE = 2,
    parameter int CH     = 1,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    pool_engine_if.master bus
);
    localparam int H_OUT = out_dim(H_IN, K, STRIDE);
    localparam int W_OUT = out_dim(W_IN, K, STRIDE);

    localparam logic [AW-1:0] PLANE_IN  = AW'(H_IN * W_IN);
    localparam logic [AW-1:0] PLANE_OUT = AW'(H_OUT * W_OUT);
    localparam logic [AW-1:0] W_IN_A    = AW'(W_IN);
    localparam logic [AW-1:0] W_OUT_A   = AW'(W_OUT);
    localparam logic [AW-1:0] STRIDE_A  = AW'(STRIDE);
    localparam logic [AW-1:0] K_LAST    = AW'(K - 1);
    localparam logic [AW-1:0] OX_LAST   = AW'(W_OUT - 1);
    localparam logic [AW-1:0] OY_LAST   = AW'(H_OUT - 1);
    localparam logic [AW-1:0] CH_LAST   = AW'(CH - 1);
    localparam bit            AVG_OK    = is_pow2(K);

    pool_state_e       state, state_nxt;
    logic [AW-1:0]     ch, oy, ox, ky, kx;
    logic              avg;
    logic              win_last_elem;
    logic              win_last;
    logic [DATA_W-1:0] result;

    assign win_last_elem = (ky == K_LAST) && (kx == K_LAST);
    assign win_last      = (ch == CH_LAST) && (oy == OY_LAST) && (ox == OX_LAST);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        bus.rd_en  = 1'b0;
        bus.wr_en  = 1'b0;
        bus.busy   = 1'b0;
        bus.intr   = 1'b0;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_READ;
            S_READ: begin
                bus.rd_en = 1'b1;
                bus.busy  = 1'b1;
                if (win_last_elem) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                bus.busy  = 1'b1;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                bus.wr_en = 1'b1;
                bus.busy  = 1'b1;
                state_nxt = win_last ? S_DONE : S_READ;
            end
            S_DONE: begin
                bus.intr = 1'b1;
                if (bus.start) state_nxt = S_READ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            avg   <= 1'b0;
            ch    <= '0;
            oy    <= '0;
            ox    <= '0;
            ky    <= '0;
            kx    <= '0;
        end else begin
            state <= state_nxt;
            // Average only divides exactly by a shift, so non-power-of-2 K falls back to max.
            if ((state == S_IDLE || state == S_DONE) && bus.start)
                avg <= AVG_OK && (bus.mode == POOL_AVG);
            if (state == S_READ) begin
                if (kx == K_LAST) begin
                    kx <= '0;
                    ky <= (ky == K_LAST) ? '0 : ky + 1'b1;
                end else begin
                    kx <= kx + 1'b1;
                end
            end
            if (state == S_WRITE) begin
                if (ox == OX_LAST) begin
                    ox <= '0;
                    if (oy == OY_LAST) begin
                        oy <= '0;
                        ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                    end else begin
                        oy <= oy + 1'b1;
                    end
                end else begin
                    ox <= ox + 1'b1;
                end
            end
        end
    end

    // Addresses and data are forced to zero whenever their strobe is low.
    assign bus.rd_addr = bus.rd_en
        ? ch * PLANE_IN + (oy * STRIDE_A + ky) * W_IN_A + ox * STRIDE_A + kx
        : '0;
    assign bus.wr_addr = bus.wr_en ? ch * PLANE_OUT + oy * W_OUT_A + ox : '0;
    assign bus.wr_data = bus.wr_en ? result : '0;

    pool_window_acc #(
        .DATA_W (DATA_W),
        .K      (K)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .issue       (bus.rd_en),
        .issue_first ((kx == '0) && (ky == '0)),
        .avg         (avg),
        .din         (bus.rd_data),
        .result      (result)
    );

endmodule
